// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A CPU-side acknowledge/EOI agent.
//   pic_state_e  : agent FSM states
//   OCW2_NS_EOI  : non-specific EOI command byte written to the PIC (A0=0)
//   *_W_DEF      : default INTA pulse / gap / EOI write widths in clk cycles
//   max3         : helper for sizing the shared phase counter
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P1      = 3'd1,
        ST_GAP     = 3'd2,
        ST_P2      = 3'd3,
        ST_HOLD    = 3'd4,
        ST_EOI_WR  = 3'd5,
        ST_EOI_REC = 3'd6
    } pic_state_e;

    localparam logic [7:0] OCW2_NS_EOI = 8'h20;

    localparam int unsigned PULSE_W_DEF = 2;
    localparam int unsigned GAP_W_DEF   = 2;
    localparam int unsigned WR_W_DEF    = 2;

    // Largest of three phase widths; the shared counter must hold it.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk, rst_n : destination clock, async active-low reset (flops clear to 0)
//   d_i        : asynchronous input
//   q_o        : synchronized output, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pic_inta_master.sv
// CPU-side agent for the 8259A INT/INTA path: synchronizes INT, runs the
// two-pulse INTA acknowledge, captures the vector on the second pulse, hands it
// to the host over valid/ready, and issues non-specific EOI writes when AEOI is
// off.
//   clk, rst_n          : clock, async active-low reset
//   int_in              : PIC INT (asynchronous)
//   inta_n              : PIC INTA strobe, active low
//   data_in             : PIC data bus, captured at the end of the second pulse
//   ack_en              : host interrupt enable, gates acknowledge start only
//   vec_valid/vec_data  : captured vector to host; vec_ready accepts it
//   eoi_req, aeoi       : host EOI request; aeoi=1 suppresses EOI writes
//   cs_n, wr_n, a0      : PIC write strobes and address for the EOI write
//   data_out, data_oe   : write data and its bus enable (high while cs_n=0)
//   busy                : FSM not idle
module pic_inta_master
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF,
    parameter int unsigned WR_W    = WR_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    output logic       inta_n,
    input  logic [7:0] data_in,
    input  logic       ack_en,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    input  logic       eoi_req,
    input  logic       aeoi,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy
);

    localparam int unsigned CNT_MAX = max3(PULSE_W, GAP_W, WR_W);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_W - 1);

    logic int_s;

    pic_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eoi_pending_q, eoi_pending_d;
    logic             inta_n_q, inta_n_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             a0_q, a0_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic             vec_valid_q, vec_valid_d;
    logic [7:0]       vec_data_q, vec_data_d;
    logic             busy_q, busy_d;

    sync_2ff u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (int_in),
        .q_o   (int_s)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            eoi_pending_q <= 1'b0;
            inta_n_q      <= 1'b1;
            cs_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            a0_q          <= 1'b0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            vec_valid_q   <= 1'b0;
            vec_data_q    <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            eoi_pending_q <= eoi_pending_d;
            inta_n_q      <= inta_n_d;
            cs_n_q        <= cs_n_d;
            wr_n_q        <= wr_n_d;
            a0_q          <= a0_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            vec_valid_q   <= vec_valid_d;
            vec_data_q    <= vec_data_d;
            busy_q        <= busy_d;
        end
    end

    // Next state, phase counter, EOI flag and output values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        eoi_pending_d = eoi_pending_q;
        vec_data_d    = vec_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (eoi_pending_q) begin
                    state_d = ST_EOI_WR;
                    cnt_d   = WR_LD;
                end else if (int_s && ack_en) begin
                    state_d = ST_P1;
                    cnt_d   = PULSE_LD;
                end
            end
            ST_P1: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // INT is deliberately not rechecked: a started acknowledge always finishes.
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_P2;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_P2: begin
                if (cnt_q == '0) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    vec_data_d = data_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (vec_valid_q && vec_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EOI_WR: begin
                if (cnt_q == '0) begin
                    state_d = ST_EOI_REC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EOI_REC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Starting the write consumes the pending request; a request arriving on
        // that same edge is kept so it gets its own write.
        if (state_d == ST_EOI_WR && state_q != ST_EOI_WR) begin
            eoi_pending_d = 1'b0;
        end
        if (eoi_req && !aeoi) begin
            eoi_pending_d = 1'b1;
        end

        // Outputs follow the state being entered so they change on the same edge.
        inta_n_d    = !(state_d == ST_P1 || state_d == ST_P2);
        cs_n_d      = (state_d != ST_EOI_WR);
        wr_n_d      = (state_d != ST_EOI_WR);
        a0_d        = 1'b0;
        data_oe_d   = (state_d == ST_EOI_WR);
        data_out_d  = (state_d == ST_EOI_WR) ? OCW2_NS_EOI : 8'h00;
        vec_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    assign inta_n    = inta_n_q;
    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign a0        = a0_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pic_inta_master.sv
// Self-checking bench for pic_inta_master: directed timing checks plus
// scoreboards for captured vectors and EOI writes.
module tb_pic_inta_master;

    localparam int unsigned PULSE_W = 2;
    localparam int unsigned GAP_W   = 2;
    localparam int unsigned WR_W    = 2;

    logic       clk;
    logic       rst_n;
    logic       int_in;
    logic       inta_n;
    logic [7:0] data_in;
    logic       ack_en;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       vec_ready;
    logic       eoi_req;
    logic       aeoi;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] vq[$];
    logic [7:0] eq[$];
    logic [7:0] cur_vec = 8'h00;
    int         pulse_cnt = 0;
    int         wr_count = 0;
    int         cs_len = 0;
    logic       prev_inta = 1'b1;
    logic       prev_cs = 1'b1;

    pic_inta_master #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .WR_W    (WR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_in    (int_in),
        .inta_n    (inta_n),
        .data_in   (data_in),
        .ack_en    (ack_en),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .eoi_req   (eoi_req),
        .aeoi      (aeoi),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: drives the PIC data bus, pops scoreboards, checks write strobes.
    always @(negedge clk) begin
        if (!rst_n) begin
            pulse_cnt = 0;
            prev_inta = 1'b1;
            prev_cs   = 1'b1;
            cs_len    = 0;
            data_in   = 8'h00;
        end else begin
            check("strobe_overlap", 32'(!inta_n && !cs_n), 32'd0);
            if (!inta_n && prev_inta) pulse_cnt++;
            // Real vector only during the second pulse; its complement elsewhere.
            data_in = (!inta_n && (pulse_cnt % 2 == 0)) ? cur_vec : ~cur_vec;
            if (vec_valid && vec_ready) begin
                if (vq.size() == 0) check("vec_unexpected", 32'(vq.size()), 32'd1);
                else check("vec_data", 32'(vec_data), 32'(vq.pop_front()));
            end
            if (!cs_n && prev_cs) begin
                wr_count++;
                cs_len = 0;
                if (eq.size() == 0) check("eoi_unexpected", 32'(eq.size()), 32'd1);
                else check("eoi_data", 32'(data_out), 32'(eq.pop_front()));
                check("eoi_a0", 32'(a0), 32'd0);
                check("eoi_after_hold", 32'(vec_valid), 32'd0);
            end
            if (!cs_n) begin
                cs_len++;
                check("eoi_wr_n", 32'(wr_n), 32'd0);
                check("eoi_oe", 32'(data_oe), 32'd1);
            end else begin
                check("idle_bus", 32'({data_oe, data_out}), 32'd0);
            end
            if (cs_n && !prev_cs) check("eoi_width", 32'(cs_len), 32'(WR_W));
            prev_inta = inta_n;
            prev_cs   = cs_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_inta(input logic v, input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inta_n == v) return;
        end
        check(tag, 32'(inta_n), 32'(v));
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vec_valid) return;
        end
        check(tag, 32'(vec_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic finish_vec(input string tag);
        wait_valid(tag);
        tick();
        vec_ready = 1'b1;
        wait_idle(tag);
        tick();
        vec_ready = 1'b0;
    endtask

    // One-cycle EOI request; the model merges while a write is still owed.
    task automatic eoi_pulse();
        tick();
        eoi_req = 1'b1;
        if (!aeoi && eq.size() == 0) eq.push_back(8'h20);
        tick();
        eoi_req = 1'b0;
    endtask

    logic [0:8] exp_inta;
    int         w0;

    initial begin
        rst_n = 1'b0; int_in = 1'b0; ack_en = 1'b1; vec_ready = 1'b0;
        eoi_req = 1'b0; aeoi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inta_n", 32'(inta_n), 32'd1);
        check("rst_cs_wr", 32'({cs_n, wr_n}), 32'd3);
        check("rst_a0", 32'(a0), 32'd0);
        check("rst_bus", 32'({data_oe, data_out}), 32'd0);
        check("rst_vec", 32'({vec_valid, vec_data}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic acknowledge: INT high before edge 0.
        cur_vec = 8'h45;
        vq.push_back(8'h45);
        int_in   = 1'b1;
        exp_inta = 9'b110011001;
        for (int k = 0; k <= 8; k++) begin
            edge_sample();
            check($sformatf("ack_inta_e%0d", k), 32'(inta_n), 32'(exp_inta[k]));
            check($sformatf("ack_valid_e%0d", k), 32'(vec_valid), 32'(k == 8));
            if (k == 1) check("busy_e1", 32'(busy), 32'd0);
            if (k == 2) check("busy_e2", 32'(busy), 32'd1);
        end
        check("vec_e8", 32'(vec_data), 32'h45);

        // Host stalls: vector stable, no new pulse.
        for (int i = 0; i < 5; i++) begin
            edge_sample();
            check("hold_data", 32'(vec_data), 32'h45);
            check("hold_valid", 32'(vec_valid), 32'd1);
            check("hold_inta", 32'(inta_n), 32'd1);
        end
        tick();
        vec_ready = 1'b1;
        cur_vec = 8'hA7;
        vq.push_back(8'hA7);
        edge_sample();
        check("hs_valid_drop", 32'(vec_valid), 32'd0);
        check("hs_inta", 32'(inta_n), 32'd1);
        edge_sample();
        check("rearm_inta", 32'(inta_n), 32'd0);
        int_in = 1'b0;
        wait_idle("rearm_idle_timeout");
        tick();
        vec_ready = 1'b0;

        // Interrupts disabled: no acknowledge until enabled.
        ack_en = 1'b0;
        int_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge_sample();
            check("ack_en0_inta", 32'(inta_n), 32'd1);
        end
        tick();
        ack_en = 1'b1;
        cur_vec = 8'h3C;
        vq.push_back(8'h3C);
        edge_sample();
        check("ack_en1_inta", 32'(inta_n), 32'd0);
        ack_en = 1'b0;
        int_in = 1'b0;
        finish_vec("ack_en_seq_timeout");
        ack_en = 1'b1;

        // EOI during GAP, AEOI off: one write after the handshake.
        w0 = wr_count;
        cur_vec = 8'h5A;
        vq.push_back(8'h5A);
        int_in = 1'b1;
        wait_inta(1'b0, "gap_p1_timeout");
        int_in = 1'b0;
        wait_inta(1'b1, "gap_timeout");
        eoi_pulse();
        finish_vec("gap_seq_timeout");
        repeat (WR_W + 6) @(negedge clk);
        check("eoi_count_aeoi0", 32'(wr_count), 32'(w0 + 1));

        // Same with AEOI on: request ignored.
        aeoi = 1'b1;
        w0 = wr_count;
        cur_vec = 8'hC3;
        vq.push_back(8'hC3);
        int_in = 1'b1;
        wait_inta(1'b0, "aeoi_p1_timeout");
        int_in = 1'b0;
        wait_inta(1'b1, "aeoi_gap_timeout");
        eoi_pulse();
        finish_vec("aeoi_seq_timeout");
        repeat (WR_W + 6) @(negedge clk);
        check("eoi_count_aeoi1", 32'(wr_count), 32'(w0));
        aeoi = 1'b0;

        // Two requests in one acknowledge merge into a single write.
        w0 = wr_count;
        cur_vec = 8'h81;
        vq.push_back(8'h81);
        int_in = 1'b1;
        wait_inta(1'b0, "merge_p1_timeout");
        int_in = 1'b0;
        eoi_pulse();
        wait_inta(1'b1, "merge_gap_timeout");
        eoi_pulse();
        finish_vec("merge_seq_timeout");
        repeat (WR_W + 6) @(negedge clk);
        check("eoi_count_merge", 32'(wr_count), 32'(w0 + 1));

        // EOI from IDLE: cs_n falls one edge after the request is sampled.
        eoi_pulse();
        @(negedge clk);
        check("eoi_idle_j", 32'(cs_n), 32'd1);
        edge_sample();
        check("eoi_idle_j1", 32'(cs_n), 32'd0);
        check("eoi_idle_data", 32'(data_out), 32'h20);
        repeat (WR_W) @(posedge clk);
        @(negedge clk);
        check("eoi_rec_cs", 32'(cs_n), 32'd1);
        check("eoi_rec_busy", 32'(busy), 32'd1);
        edge_sample();
        check("eoi_done_busy", 32'(busy), 32'd0);

        // Reset during P2 aborts; a fresh sequence follows release.
        cur_vec = 8'h99;
        int_in = 1'b1;
        wait_inta(1'b0, "rst_p1_timeout");
        wait_inta(1'b1, "rst_gap_timeout");
        wait_inta(1'b0, "rst_p2_timeout");
        rst_n = 1'b0;
        #1;
        check("rst_p2_inta", 32'(inta_n), 32'd1);
        check("rst_p2_valid", 32'(vec_valid), 32'd0);
        check("rst_p2_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_valid", 32'(vec_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        cur_vec = 8'h6E;
        vq.push_back(8'h6E);
        edge_sample();
        check("fresh_e0", 32'(inta_n), 32'd1);
        edge_sample();
        check("fresh_e1", 32'(inta_n), 32'd1);
        edge_sample();
        check("fresh_e2", 32'(inta_n), 32'd0);
        int_in = 1'b0;
        wait_valid("fresh_timeout");
        check("fresh_pulses", 32'(pulse_cnt), 32'd2);
        finish_vec("fresh_seq_timeout");

        repeat (4) @(negedge clk);
        check("vec_queue_empty", 32'(vq.size()), 32'd0);
        check("eoi_queue_empty", 32'(eq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
